// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler
//   Time-multiplexes one shared FIR MAC engine between N_CH sample channels.
//   Per-channel strobes are latched into hold registers. A round-robin
//   arbiter picks the next pending channel, and the scheduler sequences the
//   engine start/done handshake. Tagged results come back on a valid/ready port.
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_stb, in_data       per-channel sample strobe / packed samples (ch i at [i*WIDTH +: WIDTH])
//   eng_start/ch/sample   engine request (start is a 1-cycle pulse)
//   eng_done/result       engine completion and result
//   out_valid/ch/data     tagged result, held until out_ready
//   ovr_flag, ovr_clr     sticky per-channel overrun flags and their clear
//   timeout_err           1-cycle pulse when the engine fails to answer in time
// Optional feature
//   FIR_SCHED_OVR_CNT_EN  adds ovr_cnt[N_CH*16]: saturating per-channel overrun counters
module fir_channel_scheduler #(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CH_W        = $clog2(N_CH),
  parameter int unsigned TIMEOUT_CYC = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        in_stb,
  input  logic [N_CH*WIDTH-1:0]  in_data,
  output logic                   eng_start,
  output logic [CH_W-1:0]        eng_ch,
  output logic [WIDTH-1:0]       eng_sample,
  input  logic                   eng_done,
  input  logic [WIDTH-1:0]       eng_result,
  output logic                   out_valid,
  output logic [CH_W-1:0]        out_ch,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [N_CH-1:0]        ovr_flag,
  input  logic                   ovr_clr,
  output logic                   timeout_err
`ifdef FIR_SCHED_OVR_CNT_EN
  ,
  output logic [N_CH*16-1:0]     ovr_cnt
`endif
);

  localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_e;

  state_e                        state_q, state_d;
  logic [N_CH-1:0]               pending_q, pending_d;
  logic [N_CH-1:0][WIDTH-1:0]    hold_q, hold_d;
  logic [CH_W-1:0]               last_grant_q, last_grant_d;
  logic                          eng_start_q, eng_start_d;
  logic [CH_W-1:0]               eng_ch_q, eng_ch_d;
  logic [WIDTH-1:0]              eng_sample_q, eng_sample_d;
  logic                          out_valid_q, out_valid_d;
  logic [CH_W-1:0]               out_ch_q, out_ch_d;
  logic [WIDTH-1:0]              out_data_q, out_data_d;
  logic [N_CH-1:0]               ovr_flag_q, ovr_flag_d;
  logic                          timeout_err_q, timeout_err_d;
  logic [TMR_W-1:0]              timer_q, timer_d;

  logic                          grant_vld;
  logic [CH_W-1:0]               grant_idx;
  logic [N_CH-1:0]               consume;
  logic [N_CH-1:0]               overrun;
  logic                          timeout_hit;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      if (!grant_vld && pending_q[CH_W'((32'(last_grant_q) + k) % N_CH)]) begin
        grant_vld = 1'b1;
        grant_idx = CH_W'((32'(last_grant_q) + k) % N_CH);
      end
    end
  end

  // A zero TIMEOUT_CYC disables the abort path entirely.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (timer_q == TMR_W'(TIMEOUT_CYC - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; eng_done has priority over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (eng_done) state_d = OUT;
               else if (timeout_hit) state_d = IDLE;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    last_grant_d  = last_grant_q;
    eng_start_d   = 1'b0;
    eng_ch_d      = eng_ch_q;
    eng_sample_d  = eng_sample_q;
    out_valid_d   = out_valid_q;
    out_ch_d      = out_ch_q;
    out_data_d    = out_data_q;
    timeout_err_d = 1'b0;
    timer_d       = timer_q;
    consume       = '0;
    hold_d        = hold_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          consume[grant_idx] = 1'b1;
          eng_ch_d           = grant_idx;
          eng_sample_d       = hold_q[grant_idx];
          last_grant_d       = grant_idx;
          eng_start_d        = 1'b1;
        end
      end
      ISSUE: timer_d = '0;
      WAIT: begin
        if (eng_done) begin
          out_valid_d = 1'b1;
          out_ch_d    = eng_ch_q;
          out_data_d  = eng_result;
        end else if (timeout_hit) begin
          timeout_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      OUT: if (out_ready) out_valid_d = 1'b0;
      default: ;
    endcase

    // A strobe on the channel being consumed re-arms it without counting as overrun.
    overrun   = in_stb & pending_q & ~consume;
    pending_d = (pending_q & ~consume) | in_stb;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (in_stb[i]) hold_d[i] = in_data[i*WIDTH +: WIDTH];
    end
    ovr_flag_d = (ovr_clr ? '0 : ovr_flag_q) | overrun;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q     <= '0;
      hold_q        <= '0;
      last_grant_q  <= CH_W'(N_CH - 1);
      eng_start_q   <= 1'b0;
      eng_ch_q      <= '0;
      eng_sample_q  <= '0;
      out_valid_q   <= 1'b0;
      out_ch_q      <= '0;
      out_data_q    <= '0;
      ovr_flag_q    <= '0;
      timeout_err_q <= 1'b0;
      timer_q       <= '0;
    end else begin
      pending_q     <= pending_d;
      hold_q        <= hold_d;
      last_grant_q  <= last_grant_d;
      eng_start_q   <= eng_start_d;
      eng_ch_q      <= eng_ch_d;
      eng_sample_q  <= eng_sample_d;
      out_valid_q   <= out_valid_d;
      out_ch_q      <= out_ch_d;
      out_data_q    <= out_data_d;
      ovr_flag_q    <= ovr_flag_d;
      timeout_err_q <= timeout_err_d;
      timer_q       <= timer_d;
    end
  end

  assign eng_start   = eng_start_q;
  assign eng_ch      = eng_ch_q;
  assign eng_sample  = eng_sample_q;
  assign out_valid   = out_valid_q;
  assign out_ch      = out_ch_q;
  assign out_data    = out_data_q;
  assign ovr_flag    = ovr_flag_q;
  assign timeout_err = timeout_err_q;

`ifdef FIR_SCHED_OVR_CNT_EN
  logic [N_CH-1:0][15:0] ovr_cnt_q, ovr_cnt_d;

  // Saturating counters; an overrun in the clear cycle leaves a count of one.
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ovr_clr) ovr_cnt_d[i] = '0;
      if (overrun[i]) begin
        if (ovr_clr)                        ovr_cnt_d[i] = 16'd1;
        else if (ovr_cnt_q[i] != 16'hFFFF)  ovr_cnt_d[i] = ovr_cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ovr_cnt_q <= '0;
    else     ovr_cnt_q <= ovr_cnt_d;
  end

  assign ovr_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Self-checking bench for fir_channel_scheduler. A cycle-level behavioural
// model tracks expected outputs; directed scenarios and a randomized soak run
// drive the DUT and an engine stand-in.
module tb_fir_channel_scheduler;
  localparam int unsigned WIDTH = 24;
  localparam int unsigned N_CH  = 4;
  localparam int unsigned CH_W  = 2;
  localparam int unsigned TMO   = 16;
  localparam int          NC    = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       in_stb;
  logic [N_CH*WIDTH-1:0] in_data;
  logic                  eng_start;
  logic [CH_W-1:0]       eng_ch;
  logic [WIDTH-1:0]      eng_sample;
  logic                  eng_done;
  logic [WIDTH-1:0]      eng_result;
  logic                  out_valid;
  logic [CH_W-1:0]       out_ch;
  logic [WIDTH-1:0]      out_data;
  logic                  out_ready;
  logic [N_CH-1:0]       ovr_flag;
  logic                  ovr_clr;
  logic                  timeout_err;
`ifdef FIR_SCHED_OVR_CNT_EN
  logic [N_CH*16-1:0]    ovr_cnt;
`endif

  always #5 clk = ~clk;

  fir_channel_scheduler #(
    .WIDTH(WIDTH), .N_CH(N_CH), .CH_W(CH_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .in_stb(in_stb), .in_data(in_data),
    .eng_start(eng_start), .eng_ch(eng_ch), .eng_sample(eng_sample),
    .eng_done(eng_done), .eng_result(eng_result),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .out_ready(out_ready),
    .ovr_flag(ovr_flag), .ovr_clr(ovr_clr), .timeout_err(timeout_err)
`ifdef FIR_SCHED_OVR_CNT_EN
    , .ovr_cnt(ovr_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h cycle=%0d", tag, got, exp, cyc_n);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_ISSUE = 1, M_WAIT = 2, M_OUT = 3;
  int               m_mode;
  int               m_wait_cycles;
  int               m_last;
  logic [N_CH-1:0]  m_pend;
  logic [WIDTH-1:0] m_hold [N_CH];
  int               m_cnt  [N_CH];
  logic             x_start, x_ov, x_tmo;
  logic [CH_W-1:0]  x_ch, x_och;
  logic [WIDTH-1:0] x_sample, x_odata;
  logic [N_CH-1:0]  x_ovr;

  function automatic void model_reset();
    m_mode = M_IDLE; m_wait_cycles = 0; m_last = NC - 1; m_pend = '0;
    for (int i = 0; i < NC; i++) begin m_hold[i] = '0; m_cnt[i] = 0; end
    x_start = 0; x_ov = 0; x_tmo = 0; x_ch = '0; x_och = '0;
    x_sample = '0; x_odata = '0; x_ovr = '0;
  endfunction

  // Pending channel closest (cyclically) after the last grant.
  function automatic int pick();
    int best = -1;
    int bestd = NC;
    for (int i = 0; i < NC; i++) begin
      if (m_pend[i]) begin
        int d = (i - m_last - 1 + 2 * NC) % NC;
        if (d < bestd) begin bestd = d; best = i; end
      end
    end
    return best;
  endfunction

  function automatic void model_step(input logic r, input logic [N_CH-1:0] stb,
                                     input logic [N_CH*WIDTH-1:0] dat, input logic dn,
                                     input logic [WIDTH-1:0] res, input logic rdy, input logic clr);
    logic [N_CH-1:0] pend_old;
    int g;
    if (r) begin model_reset(); return; end
    pend_old = m_pend;
    g = -1;
    x_start = 0;
    x_tmo = 0;
    if (clr) begin
      x_ovr = '0;
      for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    end
    case (m_mode)
      M_IDLE: if (m_pend != 0) begin
        g = pick();
        x_ch = CH_W'(g); x_sample = m_hold[g]; m_last = g;
        x_start = 1; m_mode = M_ISSUE;
      end
      M_ISSUE: begin m_wait_cycles = 0; m_mode = M_WAIT; end
      M_WAIT: begin
        if (dn) begin x_ov = 1; x_och = x_ch; x_odata = res; m_mode = M_OUT; end
        else if (m_wait_cycles == int'(TMO) - 1) begin x_tmo = 1; m_mode = M_IDLE; end
        else m_wait_cycles++;
      end
      default: if (rdy) begin x_ov = 0; m_mode = M_IDLE; end
    endcase
    if (g >= 0) m_pend[g] = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (stb[i]) begin
        if (pend_old[i] && i != g) begin
          x_ovr[i] = 1'b1;
          m_cnt[i] = (m_cnt[i] >= 65535) ? 65535 : m_cnt[i] + 1;
        end
        m_hold[i] = dat[i*WIDTH +: WIDTH];
        m_pend[i] = 1'b1;
      end
    end
  endfunction

  task automatic compare_all();
    check("eng_start",   eng_start,   x_start);
    check("eng_ch",      eng_ch,      x_ch);
    check("eng_sample",  eng_sample,  x_sample);
    check("out_valid",   out_valid,   x_ov);
    check("out_ch",      out_ch,      x_och);
    check("out_data",    out_data,    x_odata);
    check("ovr_flag",    ovr_flag,    x_ovr);
    check("timeout_err", timeout_err, x_tmo);
`ifdef FIR_SCHED_OVR_CNT_EN
    for (int i = 0; i < NC; i++) check("ovr_cnt", ovr_cnt[i*16 +: 16], 64'(m_cnt[i]));
`endif
  endtask

  // ---------------- observation / engine stand-in ----------------
  int               grants[$];
  logic [WIDTH-1:0] samples[$];
  int start_cyc, tmo_cyc, tmo_cnt, ov_cnt, start_cnt, eng_cd;
  logic [WIDTH-1:0] last_res;

  // Drive one cycle of inputs, advance, then check and observe at the negedge.
  task automatic cyc(input logic r, input logic [N_CH-1:0] stb, input logic [N_CH*WIDTH-1:0] dat,
                     input logic dn, input logic [WIDTH-1:0] res, input logic rdy, input logic clr);
    rst = r; in_stb = stb; in_data = dat; eng_done = dn; eng_result = res;
    out_ready = rdy; ovr_clr = clr;
    if (r) eng_cd = 0;
    model_step(r, stb, dat, dn, res, rdy, clr);
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    compare_all();
    if (eng_start) begin
      grants.push_back(int'(eng_ch)); samples.push_back(eng_sample);
      start_cyc = cyc_n; start_cnt++;
    end
    if (timeout_err) begin tmo_cyc = cyc_n; tmo_cnt++; end
    if (out_valid) ov_cnt++;
  endtask

  task automatic run(input int n, input int stb_pct, input int rdy_pct, input int clr_pct,
                     input int noresp_pct, input int spur_pct, input int rst_pm);
    for (int c = 0; c < n; c++) begin
      logic [N_CH-1:0]       stb;
      logic [N_CH*WIDTH-1:0] dat;
      logic                  dn, rdy, clr, r;
      logic [WIDTH-1:0]      res;
      if (eng_start) eng_cd = (int'($urandom_range(0, 99)) < noresp_pct) ? 0 : int'($urandom_range(2, 9));
      res = WIDTH'($urandom);
      dn  = (eng_cd == 1) || (eng_cd == 0 && int'($urandom_range(0, 99)) < spur_pct);
      if (dn) last_res = res;
      if (eng_cd > 0) eng_cd--;
      for (int i = 0; i < NC; i++) begin
        stb[i] = int'($urandom_range(0, 99)) < stb_pct;
        dat[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
      rdy = int'($urandom_range(0, 99)) < rdy_pct;
      clr = int'($urandom_range(0, 99)) < clr_pct;
      r   = int'($urandom_range(0, 999)) < rst_pm;
      cyc(r, stb, dat, dn, res, rdy, clr);
    end
  endtask

  logic [N_CH*WIDTH-1:0] z, d;

  initial begin
    z = '0;
    rst = 1; in_stb = 0; in_data = 0; eng_done = 0; eng_result = 0; out_ready = 0; ovr_clr = 0;
    start_cyc = 0; tmo_cyc = 0; tmo_cnt = 0; ov_cnt = 0; start_cnt = 0; eng_cd = 0; last_res = '0;
    model_reset();
    cyc(1, 0, z, 0, 0, 0, 0);
    cyc(1, 0, z, 0, 0, 0, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_ovr_flag", ovr_flag, 0);

    // 1: single channel, engine answers 5 cycles after start
    d = '0; d[0 +: WIDTH] = 24'd100;
    cyc(0, 4'b0001, d, 0, 0, 0, 0);
    check("t1_no_start_t1", eng_start, 0);
    cyc(0, 0, z, 0, 0, 0, 0);
    check("t1_start_t2", eng_start, 1);
    check("t1_ch", eng_ch, 0);
    check("t1_sample", eng_sample, 100);
    repeat (5) cyc(0, 0, z, 0, 0, 0, 0);
    check("t1_no_valid_yet", out_valid, 0);
    cyc(0, 0, z, 1, 24'd37, 0, 0);
    check("t1_valid", out_valid, 1);
    check("t1_out_ch", out_ch, 0);
    check("t1_out_data", out_data, 37);
    cyc(0, 0, z, 0, 0, 1, 0);
    check("t1_handshake", out_valid, 0);

    // 2: all channels at once, then ch2+ch0
    cyc(1, 0, z, 0, 0, 0, 0);
    for (int i = 0; i < NC; i++) d[i*WIDTH +: WIDTH] = WIDTH'(1000 + i);
    grants.delete(); samples.delete();
    cyc(0, 4'b1111, d, 0, 0, 1, 0);
    run(100, 0, 100, 0, 0, 0, 0);
    check("t2_count", grants.size(), 4);
    for (int i = 0; i < NC; i++) begin
      if (i < grants.size()) begin
        check("t2_order", grants[i], i);
        check("t2_sample", samples[i], 1000 + i);
      end
    end
    grants.delete();
    cyc(0, 4'b0101, d, 0, 0, 1, 0);
    run(60, 0, 100, 0, 0, 0, 0);
    check("t2b_count", grants.size(), 2);
    if (grants.size() == 2) begin
      check("t2b_first", grants[0], 0);
      check("t2b_second", grants[1], 2);
    end

    // 3: ch1 overrun while engine busy on ch0
    cyc(1, 0, z, 0, 0, 0, 0);
    d = '0; d[0 +: WIDTH] = 24'd77;
    cyc(0, 4'b0001, d, 0, 0, 0, 0);
    cyc(0, 0, z, 0, 0, 0, 0);
    d = '0; d[WIDTH +: WIDTH] = 24'd5;
    cyc(0, 4'b0010, d, 0, 0, 0, 0);
    d[WIDTH +: WIDTH] = 24'd9;
    cyc(0, 4'b0010, d, 0, 0, 0, 0);
    check("t3_ovr", ovr_flag, 4'b0010);
    cyc(0, 0, z, 1, 24'd11, 0, 0);
    cyc(0, 0, z, 0, 0, 1, 0);
    grants.delete(); samples.delete();
    run(30, 0, 100, 0, 0, 0, 0);
    check("t3_count", grants.size(), 1);
    if (grants.size() > 0) begin
      check("t3_ch", grants[0], 1);
      check("t3_newest", samples[0], 9);
    end
    cyc(0, 0, z, 0, 0, 1, 1);
    check("t3_clr", ovr_flag, 0);

    // 4: engine never answers
    cyc(1, 0, z, 0, 0, 0, 0);
    d = '0; d[3*WIDTH +: WIDTH] = 24'hABCDEF;
    tmo_cnt = 0; ov_cnt = 0;
    cyc(0, 4'b1000, d, 0, 0, 1, 0);
    run(40, 0, 100, 0, 100, 0, 0);
    check("t4_tmo_count", tmo_cnt, 1);
    check("t4_tmo_delay", tmo_cyc - start_cyc, 17);
    check("t4_no_valid", ov_cnt, 0);

    // 5: downstream stall, then reset mid-WAIT
    cyc(1, 0, z, 0, 0, 0, 0);
    d = '0; d[WIDTH +: WIDTH] = 24'h123456;
    cyc(0, 4'b0010, d, 0, 0, 0, 0);
    run(20, 0, 0, 0, 0, 0, 0);
    check("t5_valid", out_valid, 1);
    start_cnt = 0;
    d = '0; d[2*WIDTH +: WIDTH] = 24'h654321;
    cyc(0, 4'b0100, d, 0, 0, 0, 0);
    run(20, 0, 0, 0, 0, 0, 0);
    check("t5_no_start", start_cnt, 0);
    check("t5_hold_ch", out_ch, 1);
    check("t5_hold_data", out_data, last_res);
    cyc(0, 0, z, 0, 0, 1, 0);
    cyc(0, 0, z, 0, 0, 0, 0);
    check("t5_next_start", eng_start, 1);
    check("t5_next_ch", eng_ch, 2);
    cyc(0, 0, z, 0, 0, 0, 0);
    cyc(1, 0, z, 0, 0, 0, 0);
    check("t5_rst_sample", eng_sample, 0);
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_ch", eng_ch, 0);

    // Randomized soak
    run(3000, 20, 60, 2, 10, 5, 2);
    run(1500, 50, 90, 1, 5, 3, 0);
    run(1500, 10, 30, 3, 30, 10, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
